mul_div_ex: RTL and testbench

MUL_DIV_EX -- requirements
Module: mul_div_ex

---
 rtl/mul_div_if.sv | 9 +
 rtl/mul_div_ex.sv | 103 ++++++++++
 tb/tb_mul_div_ex.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mul_div_if.sv
// mul_div_if: request/result bundle between the EX stage and the multiply/divide unit
// Signals: start/op/srca/srcb/flush toward the unit; busy/done/res_hi/res_lo/hiwrite/lowrite back.
interface mul_div_if;
  logic start, flush, busy, done, hiwrite, lowrite;
  logic [1:0] op;
  logic [31:0] srca, srcb, res_hi, res_lo;
  modport master (output start, op, srca, srcb, flush, input busy, done, res_hi, res_lo, hiwrite, lowrite);
  modport slave (input start, op, srca, srcb, flush, output busy, done, res_hi, res_lo, hiwrite, lowrite);
endinterface

// File: rtl/mul_div_ex.sv
// mul_div_ex: iterative 32-bit mult/multu/div/divu unit, one iteration per clock, 32-cycle latency
// Ports: clk; rst (asynchronous, active-high); bus (mul_div_if.slave) with start/op/srca/srcb/flush
// in and busy/done/res_hi/res_lo/hiwrite/lowrite out.
// Define MUL_DIV_DIV_EN to build the divider; without it op 1x completes at once with a zero result.
module mul_div_ex (
  input logic clk,
  input logic rst,
  mul_div_if.slave bus
);
`ifdef MUL_DIV_DIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam state_t div_st = DIV;
`else
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  localparam state_t div_st = DONE;
`endif
  state_t state, state_nx;
  logic [4:0] cnt;
  logic [63:0] p, p_nx, prod;
  logic [31:0] d, mag_a, mag_b, hi_nx, lo_nx;
  logic [32:0] add;
  logic neg, sa, sb, in_div, busy, accept, last;
  // p holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV;
  // d holds the multiplicand or divisor magnitude.
  assign sa = !bus.op[0] && bus.srca[31];
  assign sb = !bus.op[0] && bus.srcb[31];
  assign mag_a = sa ? -bus.srca : bus.srca;
  assign mag_b = sb ? -bus.srcb : bus.srcb;
  assign add = {1'b0, p[63:32]} + (p[0] ? {1'b0, d} : 33'd0);
  assign prod = neg ? -p_nx : p_nx;
`ifdef MUL_DIV_DIV_EN
  logic rneg, dz;
  logic [32:0] t, diff;
  logic [31:0] quo, rem;
  assign in_div = state == DIV;
  assign t = p[63:31];
  // diff[32] is the borrow: set when the shifted remainder is smaller than the divisor
  assign diff = t - {1'b0, d};
  assign p_nx = in_div ? {diff[32] ? t[31:0] : diff[31:0], p[30:0], !diff[32]} : {add, p[31:1]};
  assign quo = neg ? -p_nx[31:0] : p_nx[31:0];
  assign rem = rneg ? -p_nx[63:32] : p_nx[63:32];
  assign hi_nx = in_div ? rem : prod[63:32];
  assign lo_nx = in_div ? (dz ? 32'hFFFF_FFFF : quo) : prod[31:0];
`else
  assign in_div = 1'b0;
  assign p_nx = {add, p[31:1]};
  assign hi_nx = prod[63:32];
  assign lo_nx = prod[31:0];
`endif
  assign busy = state == MUL || in_div;
  assign accept = (state == IDLE || state == DONE) && bus.start && !bus.flush;
  assign last = cnt == 5'd31;
  assign bus.busy = busy;
  assign bus.done = state == DONE && !bus.flush;
  assign bus.hiwrite = bus.done;
  assign bus.lowrite = bus.done;
  always_comb begin
    state_nx = state;
    if (bus.flush) state_nx = IDLE;
    else if (accept) state_nx = bus.op[1] ? div_st : MUL;
    else if (busy && last) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      p <= '0;
      d <= '0;
      neg <= 1'b0;
`ifdef MUL_DIV_DIV_EN
      rneg <= 1'b0;
      dz <= 1'b0;
`endif
      bus.res_hi <= '0;
      bus.res_lo <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= '0;
        d <= bus.op[1] ? mag_b : mag_a;
        p <= {32'd0, bus.op[1] ? mag_a : mag_b};
        neg <= sa ^ sb;
`ifdef MUL_DIV_DIV_EN
        rneg <= sa;
        dz <= bus.srcb == 32'd0;
`endif
      end else if (busy) begin
        cnt <= cnt + 5'd1;
        p <= p_nx;
      end
      if (busy && last && !bus.flush) begin
        bus.res_hi <= hi_nx;
        bus.res_lo <= lo_nx;
      end
`ifndef MUL_DIV_DIV_EN
      else if (accept && bus.op[1]) begin
        bus.res_hi <= '0;
        bus.res_lo <= '0;
      end
`endif
    end
endmodule

// File: tb/tb_mul_div_ex.sv
// tb_mul_div_ex: randomized self-checking bench for mul_div_ex against an arithmetic reference model
module tb_mul_div_ex;
`ifdef MUL_DIV_DIV_EN
  localparam bit div_en = 1'b1;
`else
  localparam bit div_en = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  mul_div_if bus ();
  mul_div_ex dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint x, y, r;
    x = op[0] ? longint'(a) : longint'($signed(a));
    y = op[0] ? longint'(b) : longint'($signed(b));
    if (!op[1]) begin
      r = x * y;
      {hi, lo} = r;
    end else if (!div_en) begin
      hi = '0;
      lo = '0;
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      lo = 32'(x / y);
      hi = 32'(x % y);
    end
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit noise);
    logic [31:0] eh, el;
    int n, lat;
    model(op, a, b, eh, el);
    lat = (op[1] && !div_en) ? 0 : 32;
    bus.start = 1'b1;
    bus.op = op;
    bus.srca = a;
    bus.srcb = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_first", bus.busy, lat != 0);
    n = 0;
    while (!bus.done && n < 40) begin
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.op = 2'($urandom_range(0, 3));
        bus.srca = $urandom;
        bus.srcb = $urandom;
      end
      @(posedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    check("latency", n, lat);
    check("res_hi", bus.res_hi, eh);
    check("res_lo", bus.res_lo, el);
    check("writes", {bus.hiwrite, bus.lowrite, bus.busy}, 3'b110);
    exp_hi = eh;
    exp_lo = el;
  endtask

  task automatic idle_check();
    @(posedge clk);
    #1;
    check("done_drop", {bus.done, bus.busy}, 2'b00);
    check("hold_hi", bus.res_hi, exp_hi);
    check("hold_lo", bus.res_lo, exp_lo);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op = '0;
    bus.srca = '0;
    bus.srcb = '0;
    #2;
    check("reset_outs", {bus.busy, bus.done, bus.hiwrite, bus.lowrite}, 4'b0);
    check("reset_res", {bus.res_hi, bus.res_lo}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    idle_check();
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle_check();
    do_op(2'b11, 32'h0000_0064, 32'h0000_0000, 1'b0);
    idle_check();
    do_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    bus.flush = 1'b1;
    #1;
    check("flush_done", bus.done, 1'b0);
    bus.flush = 1'b0;
    idle_check();
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.srca = 32'hDEAD_BEEF;
    bus.srcb = 32'h0000_0007;
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      bus.start = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bus.flush = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("flush_busy", bus.busy, 1'b0);
    for (int i = 0; i < 3; i++) idle_check();
    do_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    idle_check();
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(op, a, b, i % 4 == 1);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    bus.start = 1'b1;
    bus.op = div_en ? 2'b10 : 2'b00;
    bus.srca = 32'h0BAD_F00D;
    bus.srcb = 32'h0000_0013;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_busy", bus.busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_outs", {bus.busy, bus.done, bus.hiwrite, bus.lowrite}, 4'b0);
    check("rst_res", {bus.res_hi, bus.res_lo}, 64'd0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    do_op(2'b11, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);
    idle_check();
    do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
